mem_access_unit: RTL

//  Initiator side of the word-wide data-memory port: turns CPU load/store requests (byte, half, word) into word accesses on Memory.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mau_lane_align.sv | 51 +++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the data-memory access unit.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Byte lanes touched by an access; size 3 behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a_lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << a_lo;
      SZ_HALF: m = a_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    logic bad;
    if (size == SZ_HALF)  bad = a_lo[0];
    else if (size[1])     bad = (a_lo != 2'b00);
    else                  bad = 1'b0;
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response bus and word-wide Memory port of the access unit.
interface mau_req_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (output req_valid, req_addr, req_we, req_size, req_signed, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_addr, req_we, req_size, req_signed, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface mau_mem_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic              mem_we;
  logic [31:0]       mem_wd;

  modport master (output mem_a, mem_we, mem_wd, input mem_d);
  modport slave  (input  mem_a, mem_we, mem_wd, output mem_d);
endinterface

// File: rtl/mau_lane_align.sv
// Load lane extract with sign/zero extension, and store lane merge into a read word.
module mau_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  size,
  input  logic [1:0]  a_lo,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wr_rep;
  logic [3:0]  mask;

  always_comb begin
    case (a_lo)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = a_lo[1] ? rd_word[31:16] : rd_word[15:0];

    // Store data is replicated to every lane; the mask picks which lanes land.
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        wr_rep    = {4{wr_data[7:0]}};
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        wr_rep    = {2{wr_data[15:0]}};
      end
      default: begin
        load_data = rd_word;
        wr_rep    = wr_data;
      end
    endcase

    mask       = lane_mask(size, a_lo);
    store_word = rd_word;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) store_word[8*k +: 8] = wr_rep[8*k +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns byte/half/word load-store requests into word accesses; sub-word stores use read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic     clock,
  input  logic     reset_n,
  mau_req_if.slave req,
  mau_mem_if.master mem
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        a_lo_q, a_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [31:0] load_data;
  logic [31:0] store_word;

  mau_lane_align u_align (
    .rd_word    (mem.mem_d),
    .wr_data    (wdata_q),
    .size       (size_q),
    .a_lo       (a_lo_q),
    .sign_ext   (sign_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    a_lo_d       = a_lo_q;
    wdata_d      = wdata_q;
    mem_a_d      = mem_a_q;
    mem_we_d     = 1'b0;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          we_d    = req.req_we;
          size_d  = req.req_size;
          sign_d  = req.req_signed;
          a_lo_d  = req.req_addr[1:0];
          wdata_d = req.req_wdata;
          if (ALIGN_CHECK && misaligned(req.req_size, req.req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b1;
          end else begin
            mem_a_d = {2'b00, req.req_addr[ADDR_W-1:2]};
            if (req.req_we && req.req_size[1]) begin
              state_d  = ST_WRITE;
              mem_wd_d = req.req_wdata;
              mem_we_d = 1'b1;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          state_d  = ST_WRITE;
          mem_wd_d = store_word;
          mem_we_d = 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      a_lo_q       <= 2'b00;
      wdata_q      <= 32'h0;
      mem_a_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      a_lo_q       <= a_lo_d;
      wdata_q      <= wdata_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req.req_ready  = (state_q == ST_IDLE);
  assign req.resp_valid = resp_valid_q;
  assign req.resp_rdata = resp_rdata_q;
  assign req.resp_err   = resp_err_q;
  assign mem.mem_a      = mem_a_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_wd     = mem_wd_q;

endmodule
